regfile_arbiter: RTL and testbench

Access controller between the 32x32 register file and its clients. It arbitrates two write requesters onto the register file's single write port using round-robin priority, and sequences one two-operand read requester through the read ports. The register file is written at the clock edge after `rf_wr` is sampled high; its read ports are combinational while `rf_rd` is high. The block sits between execute/load writeback and operand fetch on one side and the register file on the other.

---
 rtl/regfile_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Access controller for the 32x32 register file.
// Round-robin arbitration of two writers (A = execute, B = load) onto the
// single write port, plus a three-state sequencer that fetches two operands
// through the read ports and holds them until the next capture.
module regfile_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [AW-1:0] a_sel,
  input  logic [DW-1:0] a_val,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_sel,
  input  logic [DW-1:0] b_val,
  output logic          b_ack,
  output logic          rf_wr,
  output logic [AW-1:0] rf_selwr,
  output logic [DW-1:0] rf_wrval,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_sel1,
  input  logic [AW-1:0] rd_sel2,
  output logic          rd_ack,
  output logic [DW-1:0] rd_val1,
  output logic [DW-1:0] rd_val2,
  output logic          rf_rd,
  output logic [AW-1:0] rf_selrd1,
  output logic [AW-1:0] rf_selrd2,
  input  logic [DW-1:0] rf_rdval1,
  input  logic [DW-1:0] rf_rdval2
);

  // Identity of the most recently granted writer.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  // Read sequencer states.
  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_ACCESS = 2'd1;
  localparam logic [1:0] R_ACK    = 2'd2;

  // Register 0 is hard-wired to zero regardless of what the file returns.
  function automatic logic [DW-1:0] zero_if_r0(input logic [AW-1:0] sel,
                                               input logic [DW-1:0] val);
    return (sel == '0) ? '0 : val;
  endfunction

  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          last_q, last_d;
  logic          rf_wr_q, rf_wr_d;
  logic [AW-1:0] rf_selwr_q, rf_selwr_d;
  logic [DW-1:0] rf_wrval_q, rf_wrval_d;

  logic [1:0]    rstate_q, rstate_d;
  logic          rf_rd_q, rf_rd_d;
  logic [AW-1:0] rf_selrd1_q, rf_selrd1_d;
  logic [AW-1:0] rf_selrd2_q, rf_selrd2_d;
  logic          rd_ack_q, rd_ack_d;
  logic [DW-1:0] rd_val1_q, rd_val1_d;
  logic [DW-1:0] rd_val2_q, rd_val2_d;

  logic a_elig, b_elig, grant_a, grant_b;

  // Write arbitration: a requester whose ack is already showing is not
  // eligible, so each held request produces exactly one write.
  always_comb begin
    a_elig     = a_req & ~a_ack_q;
    b_elig     = b_req & ~b_ack_q;
    grant_a    = a_elig & (~b_elig | (last_q == LAST_B));
    grant_b    = b_elig & ~grant_a;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    rf_wr_d    = 1'b0;
    last_d     = last_q;
    rf_selwr_d = rf_selwr_q;
    rf_wrval_d = rf_wrval_q;
    if (grant_a) begin
      a_ack_d    = 1'b1;
      last_d     = LAST_A;
      rf_selwr_d = a_sel;
      rf_wrval_d = a_val;
      rf_wr_d    = (a_sel != '0);
    end else if (grant_b) begin
      b_ack_d    = 1'b1;
      last_d     = LAST_B;
      rf_selwr_d = b_sel;
      rf_wrval_d = b_val;
      rf_wr_d    = (b_sel != '0);
    end
  end

  // Read sequencer: issue selects, capture one cycle later, then one
  // cycle of ack during which a new request is ignored.
  always_comb begin
    rstate_d    = rstate_q;
    rf_rd_d     = rf_rd_q;
    rf_selrd1_d = rf_selrd1_q;
    rf_selrd2_d = rf_selrd2_q;
    rd_ack_d    = rd_ack_q;
    rd_val1_d   = rd_val1_q;
    rd_val2_d   = rd_val2_q;
    case (rstate_q)
      R_IDLE: begin
        if (rd_req) begin
          rf_selrd1_d = rd_sel1;
          rf_selrd2_d = rd_sel2;
          rf_rd_d     = 1'b1;
          rstate_d    = R_ACCESS;
        end
      end
      R_ACCESS: begin
        rd_val1_d = zero_if_r0(rf_selrd1_q, rf_rdval1);
        rd_val2_d = zero_if_r0(rf_selrd2_q, rf_rdval2);
        rf_rd_d   = 1'b0;
        rd_ack_d  = 1'b1;
        rstate_d  = R_ACK;
      end
      R_ACK: begin
        rd_ack_d = 1'b0;
        rstate_d = R_IDLE;
      end
      default: begin
        rf_rd_d  = 1'b0;
        rd_ack_d = 1'b0;
        rstate_d = R_IDLE;
      end
    endcase
  end

  // Write-path state; reset drops any write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      last_q     <= LAST_B;
      rf_wr_q    <= 1'b0;
      rf_selwr_q <= '0;
      rf_wrval_q <= '0;
    end else begin
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      last_q     <= last_d;
      rf_wr_q    <= rf_wr_d;
      rf_selwr_q <= rf_selwr_d;
      rf_wrval_q <= rf_wrval_d;
    end
  end

  // Read-path state; reset abandons any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q    <= R_IDLE;
      rf_rd_q     <= 1'b0;
      rf_selrd1_q <= '0;
      rf_selrd2_q <= '0;
      rd_ack_q    <= 1'b0;
      rd_val1_q   <= '0;
      rd_val2_q   <= '0;
    end else begin
      rstate_q    <= rstate_d;
      rf_rd_q     <= rf_rd_d;
      rf_selrd1_q <= rf_selrd1_d;
      rf_selrd2_q <= rf_selrd2_d;
      rd_ack_q    <= rd_ack_d;
      rd_val1_q   <= rd_val1_d;
      rd_val2_q   <= rd_val2_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign rf_wr     = rf_wr_q;
  assign rf_selwr  = rf_selwr_q;
  assign rf_wrval  = rf_wrval_q;
  assign rd_ack    = rd_ack_q;
  assign rd_val1   = rd_val1_q;
  assign rd_val2   = rd_val2_q;
  assign rf_rd     = rf_rd_q;
  assign rf_selrd1 = rf_selrd1_q;
  assign rf_selrd2 = rf_selrd2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter: two protocol-obeying writers, a
// random operand reader, a register file behind the block, and a
// transaction-level reference model with its own golden register contents.
module tb_regfile_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NCYC = 3000;

  logic          clk;
  logic          rst;
  logic          a_req, b_req, a_ack, b_ack;
  logic [AW-1:0] a_sel, b_sel;
  logic [DW-1:0] a_val, b_val;
  logic          rf_wr;
  logic [AW-1:0] rf_selwr;
  logic [DW-1:0] rf_wrval;
  logic          rd_req, rd_ack, rf_rd;
  logic [AW-1:0] rd_sel1, rd_sel2, rf_selrd1, rf_selrd2;
  logic [DW-1:0] rd_val1, rd_val2, rf_rdval1, rf_rdval2;

  regfile_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_sel(a_sel), .a_val(a_val), .a_ack(a_ack),
    .b_req(b_req), .b_sel(b_sel), .b_val(b_val), .b_ack(b_ack),
    .rf_wr(rf_wr), .rf_selwr(rf_selwr), .rf_wrval(rf_wrval),
    .rd_req(rd_req), .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
    .rd_ack(rd_ack), .rd_val1(rd_val1), .rd_val2(rd_val2),
    .rf_rd(rf_rd), .rf_selrd1(rf_selrd1), .rf_selrd2(rf_selrd2),
    .rf_rdval1(rf_rdval1), .rf_rdval2(rf_rdval2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behind the block. Register 0 deliberately holds a
  // non-zero pattern so the block's own zero forcing is exercised; outside
  // rf_rd the read ports return inverted data.
  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 0) ? 32'hBAD0_0000 : (32'h1000_0000 + i * 32'h0101);
  endfunction

  logic [DW-1:0] mem [32];
  logic          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (rf_wr) begin
      mem[rf_selwr] <= rf_wrval;
    end
  end
  assign rf_rdval1 = rf_rd ? mem[rf_selrd1] : ~mem[rf_selrd1];
  assign rf_rdval2 = rf_rd ? mem[rf_selrd2] : ~mem[rf_selrd2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who won last, what each output should show this
  // cycle, how far along the current read is, and the register contents
  // that should exist once all landed writes are applied.
  logic [DW-1:0] gold [32];
  bit            m_last_is_b;
  bit            m_a_ack, m_b_ack, m_wr, m_rf_rd, m_rd_ack;
  logic [AW-1:0] m_selwr, m_selrd1, m_selrd2;
  logic [DW-1:0] m_wrval, m_val1, m_val2;
  int            m_read_age;   // 0 = no read, 1 = selects out, 2 = ack cycle

  task automatic model_reset();
    m_last_is_b = 1'b1;
    m_a_ack = 0; m_b_ack = 0; m_wr = 0; m_selwr = '0; m_wrval = '0;
    m_rf_rd = 0; m_rd_ack = 0; m_selrd1 = '0; m_selrd2 = '0;
    m_val1 = '0; m_val2 = '0; m_read_age = 0;
  endtask

  // Advance the model across the next rising edge using the inputs now
  // being presented.
  task automatic model_step();
    bit want_a, want_b;
    int winner;                 // 0 none, 1 A, 2 B
    logic [DW-1:0] cap1, cap2;
    // Operand values seen at this edge exclude the write landing at it.
    cap1 = (m_selrd1 == 0) ? '0 : gold[m_selrd1];
    cap2 = (m_selrd2 == 0) ? '0 : gold[m_selrd2];
    if (m_wr) gold[m_selwr] = m_wrval;

    want_a = a_req && !m_a_ack;
    want_b = b_req && !m_b_ack;
    if (want_a && want_b) winner = m_last_is_b ? 1 : 2;
    else if (want_a)      winner = 1;
    else if (want_b)      winner = 2;
    else                  winner = 0;
    m_a_ack = (winner == 1);
    m_b_ack = (winner == 2);
    m_wr    = 0;
    if (winner != 0) begin
      m_selwr     = (winner == 1) ? a_sel : b_sel;
      m_wrval     = (winner == 1) ? a_val : b_val;
      m_wr        = (m_selwr != 0);
      m_last_is_b = (winner == 2);
    end

    if (m_read_age == 0) begin
      if (rd_req) begin
        m_selrd1 = rd_sel1; m_selrd2 = rd_sel2;
        m_rf_rd = 1; m_read_age = 1;
      end
    end else if (m_read_age == 1) begin
      m_val1 = cap1; m_val2 = cap2;
      m_rf_rd = 0; m_rd_ack = 1; m_read_age = 2;
    end else begin
      m_rd_ack = 0; m_read_age = 0;
    end
  endtask

  task automatic check_outputs();
    chk("a_ack", a_ack, m_a_ack);
    chk("b_ack", b_ack, m_b_ack);
    chk("rf_wr", rf_wr, m_wr);
    chk("rf_selwr", rf_selwr, m_selwr);
    chk("rf_wrval", rf_wrval, m_wrval);
    chk("rf_rd", rf_rd, m_rf_rd);
    chk("rf_selrd1", rf_selrd1, m_selrd1);
    chk("rf_selrd2", rf_selrd2, m_selrd2);
    chk("rd_ack", rd_ack, m_rd_ack);
    chk("rd_val1", rd_val1, m_val1);
    chk("rd_val2", rd_val2, m_val2);
  endtask

  // Writers hold req/sel/val until their ack shows, then either go idle
  // or immediately present a fresh request.
  task automatic drive_writers(input int dens);
    if (a_req && m_a_ack) a_req = 1'b0;
    if (!a_req && ($urandom_range(99) < dens)) begin
      a_req = 1'b1; a_sel = AW'($urandom_range(7)); a_val = $urandom;
    end
    if (b_req && m_b_ack) b_req = 1'b0;
    if (!b_req && ($urandom_range(99) < dens)) begin
      b_req = 1'b1; b_sel = AW'($urandom_range(7)); b_val = $urandom;
    end
  endtask

  initial begin
    int dens;
    mem_ready = 1'b0;
    a_req = 0; a_sel = '0; a_val = '0;
    b_req = 0; b_sel = '0; b_val = '0;
    rd_req = 0; rd_sel1 = '0; rd_sel2 = '0;
    for (int i = 0; i < 32; i++) gold[i] = init_val(i);
    model_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    mem_ready = 1'b1;
    rst = 1'b1;
    model_step();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_outputs();
      if ($urandom_range(99) == 0) begin
        rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
      end
      dens = (cyc < 400) ? 100 : (cyc < 1800) ? 60 : 25;
      drive_writers(dens);
      rd_req  = ($urandom_range(99) < 70);
      rd_sel1 = AW'($urandom_range(7));
      rd_sel2 = AW'($urandom_range(7));
      model_step();
    end

    @(negedge clk);
    check_outputs();
    a_req = 0; b_req = 0; rd_req = 0;
    model_step();
    @(negedge clk);
    for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), mem[i], gold[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
